// File: rtl/display_pkg.sv
// Shared display constants: coordinate width, screen border limits and
// sprite sizes used by the compositor and its neighbours.
package display_pkg;

   localparam int COORD_W_DEF         = 10;
   localparam int RIGHT_BOUNDARY_DEF  = 637;
   localparam int LEFT_BOUNDARY_DEF   = 3;
   localparam int TOP_BOUNDARY_DEF    = 3;
   localparam int BOTTOM_BOUNDARY_DEF = 477;

   localparam int PADDLE_W  = 10;
   localparam int PADDLE_H  = 46;
   localparam int BALL_SIZE = 8;

   // Width of a box index; never narrower than one bit.
   function automatic int hit_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/box_hit_stage.sv
// Strict-interior test of one pixel against one box. The far edges are
// formed at COORD_W+1 bits so a box hanging past the coordinate range
// cannot wrap around to the origin. A zero width or height never hits.
module box_hit_stage #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   input  logic               en,
   input  logic [COORD_W-1:0] x_pix,
   input  logic [COORD_W-1:0] y_pix,
   output logic               hit
);

   logic [COORD_W:0] x_end, y_end;

   // Interior comparison against all four edges.
   always_comb begin
      x_end = {1'b0, x} + {1'b0, w};
      y_end = {1'b0, y} + {1'b0, h};
      hit   = en
            && (x_pix > x) && ({1'b0, x_pix} < x_end)
            && (y_pix > y) && ({1'b0, y_pix} < y_end);
   end

endmodule

// File: rtl/box_compositor.sv
// Box compositor: per-pixel hit test against N_BOXES rectangles plus the
// screen border, with a two-stage output pipeline. Box geometry is latched
// on frame_start and held for the frame; a pixel in the frame_start cycle
// sees the new geometry directly.
// Optional macro BOX_COLLISION_EN builds the per-frame overlap accumulator
// that drives collision_flags/collision_valid; otherwise both are tied to 0.
module box_compositor
   import display_pkg::*;
#(
   parameter int N_BOXES         = 3,
   parameter int COORD_W         = COORD_W_DEF,
   parameter int RIGHT_BOUNDARY  = RIGHT_BOUNDARY_DEF,
   parameter int LEFT_BOUNDARY   = LEFT_BOUNDARY_DEF,
   parameter int TOP_BOUNDARY    = TOP_BOUNDARY_DEF,
   parameter int BOTTOM_BOUNDARY = BOTTOM_BOUNDARY_DEF,
   localparam int HIT_W          = hit_id_w(N_BOXES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic                       pix_valid,
   input  logic [COORD_W-1:0]         X_pix,
   input  logic [COORD_W-1:0]         Y_pix,
   input  logic [N_BOXES*COORD_W-1:0] box_x,
   input  logic [N_BOXES*COORD_W-1:0] box_y,
   input  logic [N_BOXES*COORD_W-1:0] box_w,
   input  logic [N_BOXES*COORD_W-1:0] box_h,
   input  logic [N_BOXES-1:0]         box_en,
   output logic                       out_valid,
   output logic                       draw,
   output logic [HIT_W-1:0]           hit_id,
   output logic                       border,
   output logic [N_BOXES-1:0]         collision_flags,
   output logic                       collision_valid
);

   localparam logic [COORD_W-1:0] LEFT_B   = COORD_W'(LEFT_BOUNDARY);
   localparam logic [COORD_W-1:0] RIGHT_B  = COORD_W'(RIGHT_BOUNDARY);
   localparam logic [COORD_W-1:0] TOP_B    = COORD_W'(TOP_BOUNDARY);
   localparam logic [COORD_W-1:0] BOTTOM_B = COORD_W'(BOTTOM_BOUNDARY);

   // Shadow geometry held across the frame.
   logic [N_BOXES*COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, sw_q, sw_d, sh_q, sh_d;
   logic [N_BOXES-1:0]         sen_q, sen_d;
   // Geometry actually used this cycle (bypass on frame_start).
   logic [N_BOXES*COORD_W-1:0] ex, ey, ew, eh;
   logic [N_BOXES-1:0]         een;

   logic [N_BOXES-1:0] hit_raw;
   logic               border_raw;

   // Valid shift register: [0] = stage 1, [1] = stage 2.
   logic [1:0]         vld_q, vld_d;
   logic [N_BOXES-1:0] hit1_q, hit1_d;
   logic               border1_q, border1_d;
   logic               draw2_q, draw2_d, border2_q, border2_d;
   logic [HIT_W-1:0]   id2_q, id2_d;

   // Shadow update and bypass selection.
   always_comb begin
      sx_d  = sx_q;
      sy_d  = sy_q;
      sw_d  = sw_q;
      sh_d  = sh_q;
      sen_d = sen_q;
      if (frame_start) begin
         sx_d  = box_x;
         sy_d  = box_y;
         sw_d  = box_w;
         sh_d  = box_h;
         sen_d = box_en;
      end
      ex  = frame_start ? box_x  : sx_q;
      ey  = frame_start ? box_y  : sy_q;
      ew  = frame_start ? box_w  : sw_q;
      eh  = frame_start ? box_h  : sh_q;
      een = frame_start ? box_en : sen_q;
   end

   for (genvar g = 0; g < N_BOXES; g++) begin : g_box
      box_hit_stage #(.COORD_W(COORD_W)) u_hit (
         .x     (ex[g*COORD_W +: COORD_W]),
         .y     (ey[g*COORD_W +: COORD_W]),
         .w     (ew[g*COORD_W +: COORD_W]),
         .h     (eh[g*COORD_W +: COORD_W]),
         .en    (een[g]),
         .x_pix (X_pix),
         .y_pix (Y_pix),
         .hit   (hit_raw[g])
      );
   end

   // Stage-1 inputs: raw hits and border test.
   always_comb begin
      border_raw = (X_pix < LEFT_B) || (X_pix > RIGHT_B)
                || (Y_pix < TOP_B)  || (Y_pix > BOTTOM_B);
      hit1_d     = hit_raw;
      border1_d  = border_raw;
      vld_d      = {vld_q[0], pix_valid};
   end

   // Stage-2 inputs: priority pick and output gating by valid.
   always_comb begin
      id2_d = '0;
      for (int i = N_BOXES - 1; i >= 0; i--) begin
         if (hit1_q[i]) id2_d = HIT_W'(i);
      end
      if (!vld_q[0]) id2_d = '0;
      draw2_d   = vld_q[0] && ((|hit1_q) || border1_q);
      border2_d = vld_q[0] && border1_q;
   end

   // Shadow and pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sx_q      <= '0;
         sy_q      <= '0;
         sw_q      <= '0;
         sh_q      <= '0;
         sen_q     <= '0;
         vld_q     <= '0;
         hit1_q    <= '0;
         border1_q <= 1'b0;
         draw2_q   <= 1'b0;
         border2_q <= 1'b0;
         id2_q     <= '0;
      end else begin
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         sw_q      <= sw_d;
         sh_q      <= sh_d;
         sen_q     <= sen_d;
         vld_q     <= vld_d;
         hit1_q    <= hit1_d;
         border1_q <= border1_d;
         draw2_q   <= draw2_d;
         border2_q <= border2_d;
         id2_q     <= id2_d;
      end
   end

   assign out_valid = vld_q[1];
   assign draw      = draw2_q;
   assign border    = border2_q;
   assign hit_id    = id2_q;

`ifdef BOX_COLLISION_EN
   logic [N_BOXES-1:0] hit2_q, hit2_d;
   logic [N_BOXES-1:0] acc_q, acc_d, flags_q, flags_d, new_bits;
   logic               cv_q, cv_d;

   // Overlap accumulation and per-frame transfer; an overlap landing in
   // the frame_start cycle belongs to the new frame.
   always_comb begin
      hit2_d   = vld_q[0] ? hit1_q : '0;
      new_bits = (vld_q[1] && |(hit2_q & (hit2_q - N_BOXES'(1)))) ? hit2_q : '0;
      acc_d    = acc_q | new_bits;
      flags_d  = flags_q;
      cv_d     = frame_start;
      if (frame_start) begin
         flags_d = acc_q;
         acc_d   = new_bits;
      end
   end

   // Collision registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit2_q  <= '0;
         acc_q   <= '0;
         flags_q <= '0;
         cv_q    <= 1'b0;
      end else begin
         hit2_q  <= hit2_d;
         acc_q   <= acc_d;
         flags_q <= flags_d;
         cv_q    <= cv_d;
      end
   end

   assign collision_flags = flags_q;
   assign collision_valid = cv_q;
`else
   assign collision_flags = '0;
   assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_box_compositor.sv
// Directed bench for box_compositor with hand-computed expectations.
module tb_box_compositor;

   localparam int N  = 3;
   localparam int CW = 10;
`ifdef BOX_COLLISION_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            frame_start = 1'b0;
   logic            pix_valid = 1'b0;
   logic [CW-1:0]   X_pix = '0, Y_pix = '0;
   logic [N*CW-1:0] box_x = '0, box_y = '0, box_w = '0, box_h = '0;
   logic [N-1:0]    box_en = '0;
   logic            out_valid, draw, border, collision_valid;
   logic [1:0]      hit_id;
   logic [N-1:0]    collision_flags;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   box_compositor #(.N_BOXES(N), .COORD_W(CW)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
      .X_pix(X_pix), .Y_pix(Y_pix), .box_x(box_x), .box_y(box_y),
      .box_w(box_w), .box_h(box_h), .box_en(box_en), .out_valid(out_valid),
      .draw(draw), .hit_id(hit_id), .border(border),
      .collision_flags(collision_flags), .collision_valid(collision_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_box(input int i, input int x, input int y, input int w,
                          input int h, input bit en);
      box_x[i*CW +: CW] = CW'(x);
      box_y[i*CW +: CW] = CW'(y);
      box_w[i*CW +: CW] = CW'(w);
      box_h[i*CW +: CW] = CW'(h);
      box_en[i]         = en;
   endtask

   // One pixel: not visible after one edge, visible after two, gone after three.
   task automatic pix(input string tag, input int x, input int y, input bit fs,
                      input bit ed, input int eid, input bit eb);
      X_pix = CW'(x); Y_pix = CW'(y); pix_valid = 1'b1; frame_start = fs;
      step();
      pix_valid = 1'b0; frame_start = 1'b0;
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_draw"},  32'(draw),      32'(ed));
      chk({tag, "_id"},    32'(hit_id),    32'(eid));
      chk({tag, "_border"},32'(border),    32'(eb));
      step();
      chk({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   // frame_start pulse with no pixel; checks the collision report.
   task automatic frame(input string tag, input logic [N-1:0] ef);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk({tag, "_cv"},     32'(collision_valid), 32'(COLL));
      chk({tag, "_flags"},  32'(collision_flags), 32'(ef));
      step();
      chk({tag, "_cv_off"}, 32'(collision_valid), 32'd0);
      chk({tag, "_hold"},   32'(collision_flags), 32'(ef));
   endtask

   initial begin
      // Reset state
      step(); step();
      chk("rst_valid",  32'(out_valid), 32'd0);
      chk("rst_draw",   32'(draw), 32'd0);
      chk("rst_id",     32'(hit_id), 32'd0);
      chk("rst_border", 32'(border), 32'd0);
      chk("rst_flags",  32'(collision_flags), 32'd0);
      chk("rst_cv",     32'(collision_valid), 32'd0);
      reset = 1'b0;
      step();

      // Basic hit and strict left edge
      set_box(0, 10, 100, 10, 46, 1'b1);
      frame("f0", 3'b000);
      pix("hit",  15, 120, 1'b0, 1'b1, 0, 1'b0);
      pix("edge", 10, 120, 1'b0, 1'b0, 0, 1'b0);

      // Mid-frame geometry change is ignored until frame_start
      set_box(0, 200, 100, 10, 46, 1'b1);
      pix("old_geo", 15, 120, 1'b0, 1'b1, 0, 1'b0);
      pix("new_pre", 205, 120, 1'b0, 1'b0, 0, 1'b0);
      pix("fs_byp",  205, 120, 1'b1, 1'b1, 0, 1'b0);
      pix("old_gone", 15, 120, 1'b0, 1'b0, 0, 1'b0);

      // Overlapping boxes 1 and 2
      set_box(0, 10, 100, 10, 46, 1'b0);
      set_box(1, 290, 190, 20, 20, 1'b1);
      set_box(2, 295, 195, 20, 20, 1'b1);
      frame("f1", 3'b000);
      pix("ovl", 300, 200, 1'b0, 1'b1, 1, 1'b0);
      frame("f2", COLL ? 3'b110 : 3'b000);
      pix("single", 292, 200, 1'b0, 1'b1, 1, 1'b0);
      frame("f3", 3'b000);

      // Screen border limits
      box_en = '0;
      frame("f4", 3'b000);
      pix("bl",   1, 240, 1'b0, 1'b1, 0, 1'b1);
      pix("br",   638, 240, 1'b0, 1'b1, 0, 1'b1);
      pix("in",   637, 477, 1'b0, 1'b0, 0, 1'b0);
      pix("bt",   300, 2, 1'b0, 1'b1, 0, 1'b1);
      pix("bb",   300, 478, 1'b0, 1'b1, 0, 1'b1);

      // No wrap-around, zero width, lowest index wins
      set_box(0, 1020, 0, 10, 10, 1'b1);
      set_box(1, 10, 100, 0, 46, 1'b1);
      set_box(2, 0, 0, 0, 0, 1'b0);
      pix("nowrap", 5, 5, 1'b1, 1'b0, 0, 1'b0);
      pix("zero_w", 11, 120, 1'b0, 1'b0, 0, 1'b0);
      set_box(0, 290, 190, 20, 20, 1'b1);
      set_box(1, 290, 190, 20, 20, 1'b1);
      pix("prio", 300, 200, 1'b1, 1'b1, 0, 1'b0);

      // Reset with pixels in flight
      X_pix = 10'd1; Y_pix = 10'd240; pix_valid = 1'b1;
      step();
      reset = 1'b1;
      step();
      pix_valid = 1'b0;
      chk("mid_valid1", 32'(out_valid), 32'd0);
      chk("mid_draw1",  32'(draw), 32'd0);
      chk("mid_border1",32'(border), 32'd0);
      chk("mid_id1",    32'(hit_id), 32'd0);
      chk("mid_flags",  32'(collision_flags), 32'd0);
      reset = 1'b0;
      step();
      chk("mid_valid2", 32'(out_valid), 32'd0);
      chk("mid_draw2",  32'(draw), 32'd0);
      chk("mid_border2",32'(border), 32'd0);
      pix("post_rst", 1, 240, 1'b0, 1'b1, 0, 1'b1);
      pix("shadow_clr", 300, 200, 1'b0, 1'b0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/box_compositor.md
BOX_COMPOSITOR -- requirements
Module: box_compositor

Interface
REQ-001 SHALL have parameter N_BOXES, default 3, giving the number of rectangular boxes (legal 1..8).
REQ-002 SHALL have parameter COORD_W, default 10, giving the width of every coordinate and size.
REQ-003 SHALL have parameters RIGHT_BOUNDARY 637, LEFT_BOUNDARY 3, TOP_BOUNDARY 3 and BOTTOM_BOUNDARY 477, giving the screen border limits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1 bit: a one-cycle pulse at the start of each frame.
REQ-007 SHALL have port pix_valid, input, 1 bit: X_pix and Y_pix are valid this cycle.
REQ-008 SHALL have ports X_pix and Y_pix, input, COORD_W bits each: the current pixel coordinate.
REQ-009 SHALL have ports box_x, box_y, box_w and box_h, input, N_BOXES*COORD_W bits each, packed with box i at slice [i*COORD_W +: COORD_W].
REQ-010 SHALL have port box_en, input, N_BOXES bits: per-box enable.
REQ-011 SHALL have port out_valid, output, 1 bit: the outputs below belong to a valid pixel.
REQ-012 SHALL have port draw, output, 1 bit: the pixel is on.
REQ-013 SHALL have port hit_id, output, $clog2(N_BOXES) bits (minimum 1): index of the winning box.
REQ-014 SHALL have port border, output, 1 bit: the pixel lies in the screen border.
REQ-015 SHALL have port collision_flags, output, N_BOXES bits: per-box overlap result for the previous frame.
REQ-016 SHALL have port collision_valid, output, 1 bit: one-cycle pulse when collision_flags updates.

Function
REQ-017 SHALL latch box_x, box_y, box_w, box_h and box_en into shadow registers on every cycle frame_start is high; these registers are held for the rest of the frame.
REQ-018 SHALL evaluate a pixel presented in the same cycle as frame_start against the new input values, which bypass the shadow registers.
REQ-019 SHALL treat box i as hit when all of the following hold: box_en[i]; X_pix > x; X_pix < x+w; Y_pix > y; Y_pix < y+h.
REQ-020 SHALL compute every sum at COORD_W+1 bits so that no wrap-around occurs; a box with w=0 or h=0 is never hit.
REQ-021 SHALL assert border when any of the following hold: X_pix < LEFT_BOUNDARY; X_pix > RIGHT_BOUNDARY; Y_pix < TOP_BOUNDARY; Y_pix > BOTTOM_BOUNDARY.
REQ-022 SHALL use a 2-stage pipeline: stage 1 registers the per-box hit bits and the border bit; stage 2 registers draw, hit_id, border and out_valid.
REQ-023 SHALL assert out_valid exactly 2 cycles after pix_valid and deassert it when pix_valid was low.
REQ-024 SHALL drive draw = (any hit) OR border when out_valid is high; draw, border and hit_id SHALL be 0 when out_valid is low.
REQ-025 SHALL make hit_id the lowest-index hit box, and 0 when no box is hit.
REQ-026 SHALL accept back-to-back pixels every cycle with no stall.
REQ-027 SHALL, for every stage-2 valid pixel with 2 or more boxes hit, set the accumulator bit of each hit box.
REQ-028 SHALL, on frame_start, transfer the accumulator to collision_flags on the next edge, pulse collision_valid high for that one cycle, and clear the accumulator.
REQ-029 SHALL add a stage-2 overlap that coincides with frame_start to the new (cleared) accumulator, not to the transferred value.
REQ-030 SHALL, when frame_start pulses on two consecutive cycles, perform both transfers, so the second transfer reports only overlaps that arrived in between.

Reset
REQ-031 SHALL, under reset, clear the shadow registers, box_en shadow, pipeline valids, accumulator, collision_flags, collision_valid, draw, border and hit_id to 0.
REQ-032 SHALL discard in-flight pixels when reset is asserted mid-frame; out_valid SHALL remain 0 until 2 cycles after the first pix_valid following reset release.

Configuration
REQ-033 SHALL build the collision logic (accumulator, collision_flags, collision_valid) only when the macro BOX_COLLISION_EN is defined.
REQ-034 SHALL, when BOX_COLLISION_EN is not defined, tie collision_flags and collision_valid to 0 and build no accumulator logic; draw timing is unchanged.

Structure
REQ-035 SHALL take the following from shared package display_pkg: COORD_W default, boundary defaults, and paddle and ball size constants.
REQ-036 SHALL implement the per-box comparison in one sub-module, box_hit_stage, instantiated N_BOXES times through a generate loop.

Verification
REQ-037 SHALL test: box0 = (10,100,10,46), enabled, pixel (15,120) -> draw=1, hit_id=0, out_valid 2 cycles later; pixel (10,120) -> draw=0 (strict edge).
REQ-038 SHALL test: boxes change mid-frame with no frame_start -> the old geometry is still drawn; after frame_start the new geometry is drawn, including for a pixel in the same cycle as frame_start.
REQ-039 SHALL test: box1 and box2 overlapping at (300,200), that pixel swept, then frame_start -> collision_flags=3'b110 with a one-cycle collision_valid; after the next frame with no overlap -> 3'b000.
REQ-040 SHALL test: pixel (1,240) with no box -> border=1, draw=1; box at x=1020, w=10, pixel (5,5) -> no hit (no wrap).
REQ-041 SHALL test: reset asserted with 2 pixels in flight -> out_valid=0 on both following cycles; all outputs 0.
REQ-042 SHALL test: BOX_COLLISION_EN undefined, the REQ-039 stimulus applied -> collision_flags=0 and collision_valid=0 throughout.
